// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sampler: FSM encoding and
// sizing helpers used by the top level and the settle timer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

  localparam int DEF_NUM_CH        = 8;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Settle counter width; never narrower than one bit so a zero-settle build still elaborates.
  function automatic int cnt_width(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_sampler_settle_timer.sv
// Settle-time counter: counts while enabled and flags the last settle cycle,
// then wraps to zero so the next channel starts from a clean count.
module settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = cnt_width(SETTLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign done = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= done ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans an N:1 mux channel by channel, waits for the output to settle after
// each select change, samples it, and hands the packed frame downstream.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SEL_W         = $clog2(NUM_CH),
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = cnt_width(SETTLE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  input  logic              y_in,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  // With no settle time every channel is sampled on consecutive cycles.
  localparam scan_state_e FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  scan_state_e       state;
  logic [NUM_CH-1:0] shadow;
  logic [SEL_W:0]    sel_inc;
  logic              tmr_done;

  assign sel_inc = {1'b0, sel} + 1'b1;

  generate
    if (SETTLE_CYCLES > 0) begin : g_tmr
      settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
      ) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (abort || (state != SETTLE)),
        .enable (state == SETTLE),
        .done   (tmr_done)
      );
    end else begin : g_no_tmr
      assign tmr_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (abort) begin
      // frame keeps the last completed scan; only in-flight state is dropped
      state       <= IDLE;
      sel         <= '0;
      shadow      <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FIRST;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (tmr_done) state <= SAMPLE;
        end
        SAMPLE: begin
          shadow[sel] <= y_in;
          if (sel == LAST_SEL) begin
            // last bit goes straight from y_in so the frame is complete this edge
            frame       <= {y_in, shadow[NUM_CH-2:0]};
            frame_valid <= 1'b1;
            sel         <= '0;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            sel   <= sel_inc[SEL_W-1:0];
            state <= FIRST;
          end
        end
        DONE: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (start) begin
              state <= FIRST;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n && !abort && state == SAMPLE && sel != LAST_SEL)
      assert (sel_inc <= (SEL_W+1)'(NUM_CH - 1))
        else $error("sel increment overflow");
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Randomized scoreboard bench: each accepted start pushes the expected frame
// and completion edge; a negedge monitor checks every frame the DUT raises.
module tb_mux_scan_sampler;

  localparam int N   = 8;
  localparam int S   = 2;
  localparam int SW  = 3;
  localparam int LAT = N * (S + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, abort, frame_ready;
  logic [SW-1:0] sel;
  logic [N-1:0]  a_vec, frame;
  logic          y_in, frame_valid, busy;

  logic          start0, ready0;
  logic [SW-1:0] sel0;
  logic [N-1:0]  a0, frame0;
  logic          y0, valid0, busy0;
  logic          abort0 = 1'b0;

  always #5 clk = ~clk;

  // behavioural 8:1 mux: Y = A[S]
  assign y_in = a_vec[sel];
  assign y0   = a0[sel0];

  mux_scan_sampler #(.NUM_CH(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
    .y_in(y_in), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy)
  );

  mux_scan_sampler #(.NUM_CH(N), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .sel(sel0),
    .y_in(y0), .frame(frame0), .frame_valid(valid0),
    .frame_ready(ready0), .busy(busy0)
  );

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct { logic [N-1:0] frame; int edge_n; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at edge %0d", name, act, exp, edges);
    end
  endtask

  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst_n && frame_valid && !prev_v) begin
      if (sbq.size() == 0) chk("unexpected_frame", 32'(frame_valid), 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("frame", 32'(frame), 32'(e.frame));
        chk("latency", edges, e.edge_n);
      end
    end
    prev_v = frame_valid;
  end

  // Called just after a negedge. abort_k >= 0 aborts after the k-th scan edge.
  task automatic scan(input logic [N-1:0] a, input int abort_k, input bit b2b);
    int e0;
    a_vec = a;
    start = 1'b1;
    if (b2b) frame_ready = 1'b1;
    e0 = edges + 1;
    if (abort_k < 0) sbq.push_back('{a, e0 + LAT});
    @(negedge clk);
    start = 1'b0;
    frame_ready = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      chk("sel_step", 32'(sel), 32'(k / (S + 1)));
      chk("busy_scan", 32'(busy), 32'd1);
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sel", 32'(sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(frame_valid), 32'd0);
        return;
      end
      @(negedge clk);
    end
    chk("busy_done", 32'(busy), 32'd0);
    chk("valid_done", 32'(frame_valid), 32'd1);
  endtask

  task automatic accept(input logic [N-1:0] a, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("hold_valid", 32'(frame_valid), 32'd1);
      chk("hold_frame", 32'(frame), 32'(a));
      @(negedge clk);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("accept_valid", 32'(frame_valid), 32'd0);
    chk("keep_frame", 32'(frame), 32'(a));
  endtask

  task automatic scan0(input logic [N-1:0] a);
    int  e0;
    bit  seen;
    a0 = a;
    start0 = 1'b1;
    e0 = edges + 1;
    seen = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (valid0) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("s0_timeout", 32'd0, 32'd1);
    else begin
      chk("s0_latency", edges, e0 + N);
      chk("s0_frame", 32'(frame0), 32'(a));
    end
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] a, a_prev;
    int  ak;
    bit  b2b, in_done;
    start = 0; abort = 0; frame_ready = 0; a_vec = '0;
    start0 = 0; ready0 = 0; a0 = '0;
    a_prev = '0; in_done = 0;

    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    scan(8'hA5, -1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(frame_valid), 32'd1);
      chk("hold_frame", 32'(frame), 32'hA5);
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    accept(8'hA5, 0);
    chk("idle_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("start_ignored", 32'(busy), 32'd0);
    end

    scan(8'h5A, -1, 0);
    scan(8'h3C, -1, 1);
    accept(8'h3C, 2);

    scan(8'(($urandom)), 12, 0);
    repeat (30) @(negedge clk);
    chk("post_abort_idle", 32'(busy), 32'd0);
    scan(8'hFF, -1, 0);
    accept(8'hFF, 1);

    a_vec = 8'h81;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_frame", 32'(frame), 32'd0);
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_frame", 32'(frame_valid), 32'd0);

    repeat (10) begin
      a   = 8'($urandom);
      ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
      b2b = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !b2b) accept(a_prev, int'($urandom_range(0, 4)));
      scan(a, ak, b2b);
      in_done = (ak < 0);
      a_prev  = a;
    end
    if (in_done) accept(a_prev, 1);

    scan0(8'h96);
    scan0(8'($urandom));

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
